// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, register-file geometry and the register index type.
package mips_pkg;

  localparam int NREG_DEF   = 32;
  localparam int RADDR_DEF  = 5;
  localparam int WB_LAT_DEF = 3;

  typedef logic [RADDR_DEF-1:0] reg_idx_t;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_OR   = 6'h0d;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_HLT  = 6'h3f;

endpackage

// File: rtl/reg_scoreboard_if.sv
// ID-stage issue bus between the decoder (master) and the register scoreboard (slave).
interface reg_scoreboard_if
  import mips_pkg::*;
#(
    parameter int NREG  = NREG_DEF,
    parameter int RADDR = RADDR_DEF
);
    logic             issue_valid;
    logic             issue_wr;
    logic             issue_load;
    logic [RADDR-1:0] issue_rd;
    logic [RADDR-1:0] issue_rs;
    logic             issue_rs_use;
    logic [RADDR-1:0] issue_rt;
    logic             issue_rt_use;
    logic             issue_halt;
    logic             flush;
    logic             stall;
    logic             issue_fire;
    logic             halted;
    logic             busy;
    logic [NREG-1:0]  pending_mask;

    modport master (
        output issue_valid, issue_wr, issue_load, issue_rd, issue_rs, issue_rs_use,
               issue_rt, issue_rt_use, issue_halt, flush,
        input  stall, issue_fire, halted, busy, pending_mask
    );

    modport slave (
        input  issue_valid, issue_wr, issue_load, issue_rd, issue_rs, issue_rs_use,
               issue_rt, issue_rt_use, issue_halt, flush,
        output stall, issue_fire, halted, busy, pending_mask
    );
endinterface

// File: rtl/sb_entry.sv
// One architectural register's write-back countdown and load flag.
// SB_FORWARD_EN selects the bypassed (load-use only) read-blocking rule.
module sb_entry #(
    parameter  int WB_LAT = 3,
    localparam int CW     = $clog2(WB_LAT + 1)
) (
    input  logic          clk1,
    input  logic          rst,
    input  logic          load,
    input  logic          load_is_ld,
    input  logic          flush,
    output logic [CW-1:0] cnt,
    output logic          ld,
    output logic          pending,
    output logic          blocks
);

    // NOTE: non-blocking assignments so every entry updates from the same pre-edge state.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            ld  <= 1'b0;
        end else if (load) begin
            cnt <= CW'(WB_LAT);
            ld  <= load_is_ld;
        end else if (flush && cnt == CW'(WB_LAT)) begin
            cnt <= '0;
            ld  <= 1'b0;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
            ld  <= ld && (cnt != CW'(1));
        end
    end

    assign pending = (cnt != '0);

    // The last count is the write-back cycle; the register file writes before it is read.
`ifdef SB_FORWARD_EN
    assign blocks = ld && (cnt == CW'(WB_LAT));
`else
    assign blocks = (cnt > CW'(1));
`endif

endmodule

// File: rtl/reg_scoreboard.sv
// Register-hazard interlock between ID and EX: per-register write tracking, stall, flush cancel, halt drain.
// Optional bypass mode is selected by the SB_FORWARD_EN macro (see sb_entry).
module reg_scoreboard
  import mips_pkg::*;
#(
    parameter int NREG   = NREG_DEF,
    parameter int RADDR  = RADDR_DEF,
    parameter int WB_LAT = WB_LAT_DEF
) (
    input logic             clk1,
    input logic             rst,
    reg_scoreboard_if.slave sb
);

    localparam int CW    = $clog2(WB_LAT + 1);
    localparam int RFULL = 2 ** RADDR;

    logic [NREG-1:0]  pend;
    logic [NREG-1:0]  blk;
    logic [RFULL-1:0] blk_full;
    logic             rs_hz;
    logic             rt_hz;
    logic             wr_en;
    logic             halted_q;

    // R0 is hard-wired zero and never tracked.
    assign pend[0] = 1'b0;
    assign blk[0]  = 1'b0;

    assign wr_en = sb.issue_fire && sb.issue_wr;

    for (genvar gi = 1; gi < NREG; gi++) begin : g_entry
        logic [CW-1:0] cnt;
        logic          ld;

        sb_entry #(.WB_LAT(WB_LAT)) u_entry (
            .clk1       (clk1),
            .rst        (rst),
            .load       (wr_en && sb.issue_rd == RADDR'(gi)),
            .load_is_ld (sb.issue_load),
            .flush      (sb.flush),
            .cnt        (cnt),
            .ld         (ld),
            .pending    (pend[gi]),
            .blocks     (blk[gi])
        );
    end

    // Zero-extended so that source indices beyond NREG read as never blocked.
    assign blk_full = RFULL'(blk);
    assign rs_hz    = sb.issue_rs_use && blk_full[sb.issue_rs];
    assign rt_hz    = sb.issue_rt_use && blk_full[sb.issue_rt];

    assign sb.stall      = sb.issue_valid && (rs_hz || rt_hz) && !halted_q;
    assign sb.issue_fire = sb.issue_valid && !sb.stall && !sb.flush && !halted_q;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else if (sb.issue_fire && sb.issue_halt) begin
            halted_q <= 1'b1;
        end
    end

    assign sb.halted       = halted_q;
    assign sb.pending_mask = pend;
    assign sb.busy         = |pend;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus random traffic against a cycle-stamp model.
module tb_reg_scoreboard;

    localparam int NREG   = 32;
    localparam int RADDR  = 5;
    localparam int WB_LAT = 3;
    localparam int NEVER  = -1000;

    logic clk1 = 1'b0;
    logic rst  = 1'b1;

    reg_scoreboard_if #(.NREG(NREG), .RADDR(RADDR)) sb ();

    reg_scoreboard #(.NREG(NREG), .RADDR(RADDR), .WB_LAT(WB_LAT)) dut (
        .clk1 (clk1),
        .rst  (rst),
        .sb   (sb)
    );

    always #5 clk1 = ~clk1;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the cycle each register's write fired, and whether it was a load.
    int fire_cyc [NREG];
    bit ld_m     [NREG];
    bit halted_m;
    int now;

    bit v, wr, ldi, rsu, rtu, hlt, fl;
    int rd, rs, rt;

    logic            obs_stall, obs_fire, obs_busy, obs_halted;
    logic [NREG-1:0] obs_mask;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, now);
        end
    endtask

    function automatic bit m_pending(input int r);
        return r != 0 && now > fire_cyc[r] && now <= fire_cyc[r] + WB_LAT;
    endfunction

    function automatic bit m_blocks(input int r);
        if (r == 0 || r >= NREG) return 1'b0;
`ifdef SB_FORWARD_EN
        return ld_m[r] && now == fire_cyc[r] + 1;
`else
        return now > fire_cyc[r] && now < fire_cyc[r] + WB_LAT;
`endif
    endfunction

    function automatic bit m_stall();
        return v && ((rsu && m_blocks(rs)) || (rtu && m_blocks(rt))) && !halted_m;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < NREG; r++) begin
            fire_cyc[r] = NEVER;
            ld_m[r]     = 1'b0;
        end
        halted_m = 1'b0;
    endtask

    task automatic set_ins(input bit v_, input bit wr_, input bit ld_, input int rd_, input int rs_,
                           input int rt_, input bit rsu_, input bit rtu_, input bit hlt_, input bit fl_);
        v = v_; wr = wr_; ldi = ld_; rd = rd_; rs = rs_; rt = rt_;
        rsu = rsu_; rtu = rtu_; hlt = hlt_; fl = fl_;
        sb.issue_valid  = v;
        sb.issue_wr     = wr;
        sb.issue_load   = ldi;
        sb.issue_rd     = RADDR'(rd);
        sb.issue_rs     = RADDR'(rs);
        sb.issue_rt     = RADDR'(rt);
        sb.issue_rs_use = rsu;
        sb.issue_rt_use = rtu;
        sb.issue_halt   = hlt;
        sb.flush        = fl;
    endtask

    task automatic idle();           set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic addi(input int d); set_ins(1, 1, 0, d, 0, 0, 1, 0, 0, 0); endtask
    task automatic lw(input int d);   set_ins(1, 1, 1, d, 0, 0, 1, 0, 0, 0); endtask
    task automatic add(input int d, input int a, input int b); set_ins(1, 1, 0, d, a, b, 1, 1, 0, 0); endtask

    // One cycle: inputs already driven at the falling edge; compare, then advance the model at the rising edge.
    task automatic tick();
        logic [NREG-1:0] em;
        bit es, ef;
        #1;
        es = m_stall();
        ef = v && !es && !fl && !halted_m;
        em = '0;
        for (int r = 1; r < NREG; r++) em[r] = m_pending(r);
        check("stall",        sb.stall,        es);
        check("issue_fire",   sb.issue_fire,   ef);
        check("pending_mask", sb.pending_mask, em);
        check("busy",         sb.busy,         |em);
        check("halted",       sb.halted,       halted_m);
        obs_stall  = sb.stall;
        obs_fire   = sb.issue_fire;
        obs_busy   = sb.busy;
        obs_halted = sb.halted;
        obs_mask   = sb.pending_mask;
        @(posedge clk1);
        if (fl) begin
            for (int r = 0; r < NREG; r++)
                if (fire_cyc[r] == now - 1) fire_cyc[r] = NEVER;
        end
        if (ef && wr && rd != 0 && rd < NREG) begin
            fire_cyc[rd] = now;
            ld_m[rd]     = ldi;
        end
        if (ef && hlt) halted_m = 1'b1;
        now++;
        @(negedge clk1);
    endtask

    // Asynchronous reset pulse placed between clock edges; outputs must clear without waiting for an edge.
    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        #2;
        check({tag, "_stall"},   sb.stall,        1'b0);
        check({tag, "_pending"}, sb.pending_mask, '0);
        check({tag, "_busy"},    sb.busy,         1'b0);
        check({tag, "_halted"},  sb.halted,       1'b0);
        model_clear();
        @(negedge clk1);
        rst = 1'b0;
    endtask

    // Present ADD d,a,b until it fires; reports stall count and cycles spent.
    task automatic issue_wait(input int d, input int a, input int b, output int stalls, output int cycles);
        bit fired = 1'b0;
        stalls = 0;
        cycles = 0;
        for (int k = 0; k < 20 && !fired; k++) begin
            add(d, a, b);
            tick();
            cycles++;
            if (obs_fire) fired = 1'b1;
            else if (obs_stall) stalls++;
        end
        check("fire_within_bound", fired, 1'b1);
        idle();
    endtask

`ifdef SB_FORWARD_EN
    localparam int EXP_ALU_STALLS  = 0;
    localparam int EXP_LOAD_STALLS = 1;
    localparam int EXP_WAW_FIRE    = 2;
`else
    localparam int EXP_ALU_STALLS  = WB_LAT - 1;
    localparam int EXP_LOAD_STALLS = WB_LAT - 1;
    localparam int EXP_WAW_FIRE    = 1 + WB_LAT;
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int stalls, cycles, drain;
        bit any_stall;

        now = 0;
        model_clear();
        idle();
        @(negedge clk1);
        @(negedge clk1);
        check("reset_pending", sb.pending_mask, '0);
        check("reset_busy",    sb.busy,         1'b0);
        check("reset_halted",  sb.halted,       1'b0);
        rst = 1'b0;

        // Back-to-back ALU dependence.
        addi(1); tick();
        issue_wait(4, 1, 2, stalls, cycles);
        check("alu_dep_stalls", stalls, EXP_ALU_STALLS);
        do_reset("rst_a");

        // Load-use dependence.
        lw(1); tick();
        issue_wait(4, 1, 2, stalls, cycles);
        check("load_use_stalls", stalls, EXP_LOAD_STALLS);
        do_reset("rst_b");

        // Independent stream.
        any_stall = 1'b0;
        for (int r = 1; r <= 3; r++) begin
            addi(r); tick();
            any_stall |= obs_stall;
        end
        idle(); tick();
        check("indep_no_stall", any_stall, 1'b0);
        check("indep_mask_c3",  obs_mask,  32'h0000_000E);
        do_reset("rst_c");

        // R0 is never tracked.
        addi(0); tick();
        idle(); tick();
        check("r0_mask", obs_mask, '0);

        // WAW on R5: the later write sets the countdown.
        addi(5); tick();
        addi(5); tick();
        issue_wait(4, 5, 5, stalls, cycles);
        check("waw_fire_cycle", 2 + cycles - 1, EXP_WAW_FIRE);
        do_reset("rst_d");

        // Branch flush cancels the write issued the cycle before.
        addi(6); tick();
        add(7, 1, 2); fl = 1'b1; sb.flush = 1'b1; tick();
        check("flush_no_fire", obs_fire, 1'b0);
        idle(); tick();
        check("flush_mask6", obs_mask[6], 1'b0);
        issue_wait(8, 6, 6, stalls, cycles);
        check("flush_read_stalls", stalls, 0);
        do_reset("rst_e");

        // Halt with R4 pending: no further issue, pending writes drain.
        addi(4); tick();
        set_ins(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
        check("halt_fired", obs_fire, 1'b1);
        drain = -1;
        for (int k = 0; k <= WB_LAT + 1; k++) begin
            addi(9); tick();
            check("halted_no_fire", obs_fire, 1'b0);
            check("halted_flag", obs_halted, 1'b1);
            if (!obs_busy && drain < 0) drain = k;
        end
        check("halt_drain_bound", (drain >= 0 && drain <= WB_LAT), 1'b1);

        // Reset in the middle of a stall.
        do_reset("rst_f");
        addi(1); tick();
        add(4, 1, 2);
        do_reset("rst_mid_stall");
        idle();

        // Random traffic over a small register window to force frequent hazards.
        for (int n = 0; n < 600; n++) begin
            if (n % 80 == 79) do_reset("rst_rand");
            set_ins($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 60) == 0, $urandom_range(0, 9) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
